// File: rtl/sprite_painter_if.sv
// sprite_painter_if: render-slot, sprite-ROM and framebuffer signals of the painter.
//   frame_start      vblank paint request (runner/scan-out -> painter)
//   sprite[s]        {sheet_x, sheet_y, w, h}, 12-bit unsigned each
//   pos[s]           {x, y}, 12-bit signed each (canvas position)
//   rom_addr/rom_data  sprite-sheet ROM port, data valid 1 cycle after address
//   fb_we/fb_addr/fb_data  framebuffer write port
//   fb_sel           back buffer being painted
//   painter_finished high while idle with a completed frame
//   overrun          pulse when frame_start arrives while busy
interface sprite_painter_if #(
  parameter int RENDER_SLOTS = 32,
  parameter int ROM_AW       = 19,
  parameter int FB_AW        = 19,
  parameter int PIX_W        = 2
);
  logic                          frame_start;
  logic [RENDER_SLOTS-1:0][47:0] sprite;
  logic [RENDER_SLOTS-1:0][23:0] pos;
  logic [ROM_AW-1:0]             rom_addr;
  logic [PIX_W-1:0]              rom_data;
  logic                          fb_we;
  logic [FB_AW-1:0]              fb_addr;
  logic [PIX_W-1:0]              fb_data;
  logic                          fb_sel;
  logic                          painter_finished;
  logic                          overrun;

  modport master (
    output frame_start, sprite, pos, rom_data,
    input  rom_addr, fb_we, fb_addr, fb_data, fb_sel, painter_finished, overrun
  );

  modport slave (
    input  frame_start, sprite, pos, rom_data,
    output rom_addr, fb_we, fb_addr, fb_data, fb_sel, painter_finished, overrun
  );
endinterface

// File: rtl/sprite_painter.sv
// sprite_painter: on frame_start, snapshots all render slots, clears the back
// framebuffer, then blits every non-empty slot from the sprite-sheet ROM in slot
// order (slot 0 bottom). Off-canvas and transparent (0) pixels are not written.
// Ports:
//   clk   system clock
//   rst   asynchronous active-low reset
//   bus   sprite_painter_if.slave (slots, ROM port, framebuffer port, status)
module sprite_painter #(
  parameter int RENDER_SLOTS = 32,
  parameter int CANVAS_W     = 1280,
  parameter int CANVAS_H     = 300,
  parameter int SHEET_W      = 2446,
  parameter int ROM_AW       = 19,
  parameter int FB_AW        = 19,
  parameter int PIX_W        = 2
) (
  input logic              clk,
  input logic              rst,
  sprite_painter_if.slave  bus
);

  localparam int IW = $clog2(RENDER_SLOTS + 1);
  localparam int SW = $clog2(RENDER_SLOTS);
  localparam logic [FB_AW-1:0] FB_LAST = FB_AW'(CANVAS_W * CANVAS_H - 1);
  localparam logic [12:0]      CW13    = 13'(CANVAS_W);
  localparam logic [12:0]      CH13    = 13'(CANVAS_H);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_BLIT  = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]                    state;
  logic [RENDER_SLOTS-1:0][47:0] snap_spr;
  logic [RENDER_SLOTS-1:0][23:0] snap_pos;
  logic [FB_AW-1:0]              clr_addr;
  logic [IW-1:0]                 idx;
  logic [11:0]                   col, row;
  logic                          p_valid, p_inb;
  logic [FB_AW-1:0]              p_addr;
  logic                          fb_sel_q, finished_q, overrun_q;

  logic [SW-1:0]     idx_s;
  logic [11:0]       sheet_x, sheet_y, spr_w, spr_h, pos_x, pos_y;
  logic [12:0]       dx, dy;
  logic              in_bounds, slot_empty, last_col, last_row;
  logic [ROM_AW-1:0] issue_rom;
  logic [FB_AW-1:0]  issue_fb;

  // idx == RENDER_SLOTS aliases slot 0 here; that value only selects DRAIN.
  assign idx_s   = idx[SW-1:0];
  assign sheet_x = snap_spr[idx_s][47:36];
  assign sheet_y = snap_spr[idx_s][35:24];
  assign spr_w   = snap_spr[idx_s][23:12];
  assign spr_h   = snap_spr[idx_s][11:0];
  assign pos_x   = snap_pos[idx_s][23:12];
  assign pos_y   = snap_pos[idx_s][11:0];

  // 13-bit two's complement canvas coordinates; bit 12 is the sign.
  assign dx = {pos_x[11], pos_x} + {1'b0, col};
  assign dy = {pos_y[11], pos_y} + {1'b0, row};
  assign in_bounds = !dx[12] && (dx < CW13) && !dy[12] && (dy < CH13);

  assign issue_rom = (ROM_AW'(sheet_y) + ROM_AW'(row)) * ROM_AW'(SHEET_W)
                   + ROM_AW'(sheet_x) + ROM_AW'(col);
  assign issue_fb  = FB_AW'(dy[11:0]) * FB_AW'(CANVAS_W) + FB_AW'(dx[11:0]);

  assign slot_empty = (spr_w == 12'd0) || (spr_h == 12'd0);
  assign last_col   = (col == spr_w - 12'd1);
  assign last_row   = (row == spr_h - 12'd1);

  // Write stage is combinational on the pipeline register so that ROM data
  // arriving one cycle after issue lines up with its address.
  assign bus.rom_addr         = (state == S_BLIT) ? issue_rom : '0;
  assign bus.fb_we            = (state == S_CLEAR) ||
                                (p_valid && p_inb && (bus.rom_data != '0));
  assign bus.fb_addr          = p_valid ? p_addr : clr_addr;
  assign bus.fb_data          = p_valid ? bus.rom_data : '0;
  assign bus.fb_sel           = fb_sel_q;
  assign bus.painter_finished = finished_q;
  assign bus.overrun          = overrun_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      snap_spr   <= '0;
      snap_pos   <= '0;
      clr_addr   <= '0;
      idx        <= '0;
      col        <= '0;
      row        <= '0;
      p_valid    <= 1'b0;
      p_inb      <= 1'b0;
      p_addr     <= '0;
      fb_sel_q   <= 1'b0;
      finished_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      overrun_q <= bus.frame_start && (state != S_IDLE);
      p_valid   <= (state == S_BLIT);
      p_inb     <= in_bounds;
      p_addr    <= issue_fb;
      case (state)
        S_IDLE: begin
          if (bus.frame_start) begin
            snap_spr   <= bus.sprite;
            snap_pos   <= bus.pos;
            finished_q <= 1'b0;
            clr_addr   <= '0;
            state      <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          if (clr_addr == FB_LAST) begin
            clr_addr <= '0;
            idx      <= '0;
            state    <= S_LOAD;
          end else begin
            clr_addr <= clr_addr + FB_AW'(1);
          end
        end
        S_LOAD: begin
          if (idx == IW'(RENDER_SLOTS)) begin
            state <= S_DRAIN;
          end else if (slot_empty) begin
            idx <= idx + IW'(1);
          end else begin
            col   <= '0;
            row   <= '0;
            state <= S_BLIT;
          end
        end
        S_BLIT: begin
          if (last_col) begin
            col <= '0;
            if (last_row) begin
              idx   <= idx + IW'(1);
              state <= S_LOAD;
            end else begin
              row <= row + 12'd1;
            end
          end else begin
            col <= col + 12'd1;
          end
        end
        S_DRAIN: state <= S_DONE;
        S_DONE: begin
          fb_sel_q   <= ~fb_sel_q;
          finished_q <= 1'b1;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_painter.sv
// tb_sprite_painter: drives sprite_painter on a reduced 64x20 canvas and checks
// every framebuffer write against an expected write list computed from the
// slot contents, plus frame time, buffer toggle, overrun and reset behaviour.
module tb_sprite_painter;
  localparam int SLOTS = 32;
  localparam int CW    = 64;
  localparam int CH    = 20;
  localparam int SHW   = 2446;
  localparam int RAW   = 19;
  localparam int FAW   = 19;
  localparam int PW    = 2;
  localparam int NPIX  = CW * CH;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sprite_painter_if #(.RENDER_SLOTS(SLOTS), .ROM_AW(RAW), .FB_AW(FAW), .PIX_W(PW)) bus ();

  sprite_painter #(
    .RENDER_SLOTS(SLOTS), .CANVAS_W(CW), .CANVAS_H(CH), .SHEET_W(SHW),
    .ROM_AW(RAW), .FB_AW(FAW), .PIX_W(PW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    int addr;
    int data;
    bit has_rom;
    int rom;
  } wr_t;

  int  errors = 0;
  int  checks = 0;
  int  cyc = 0;
  int  rom_mode = 2;
  wr_t exp_q[$];
  int  fb_mem[NPIX];
  int  fb_exp[NPIX];
  int  sx[SLOTS], sy[SLOTS], sw[SLOTS], sh[SLOTS], px[SLOTS], py[SLOTS];
  int  exp_t, last_t;
  int  sprite_writes, first_rom, first_addr, ovr_cnt, prev_rom;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Sheet content: 0 = pixel value is sheet row mod 4, 2 = all 3, else hashed.
  function automatic int rom_pix(input int a);
    logic [31:0] h;
    if (rom_mode == 0) return (a / SHW) % 4;
    if (rom_mode == 2) return 3;
    h = 32'(a) * 32'd2654435761;
    return int'(h[14:13]);
  endfunction

  always @(posedge clk) bus.rom_data <= 2'(rom_pix(int'(bus.rom_addr)));
  always @(posedge clk) cyc <= cyc + 1;

  // Expected frame: full clear in address order, then every visible opaque
  // pixel of each non-empty slot in slot/row/column order.
  task automatic build_model();
    int area, ra, dxi, dyi, p;
    exp_q.delete();
    area = 0;
    for (int a = 0; a < NPIX; a++) begin
      exp_q.push_back('{a, 0, 1'b0, 0});
      fb_exp[a] = 0;
    end
    for (int s = 0; s < SLOTS; s++) begin
      if (sw[s] > 0 && sh[s] > 0) begin
        area += sw[s] * sh[s];
        for (int r = 0; r < sh[s]; r++)
          for (int c = 0; c < sw[s]; c++) begin
            ra  = (sy[s] + r) * SHW + sx[s] + c;
            dxi = px[s] + c;
            dyi = py[s] + r;
            p   = rom_pix(ra);
            if (dxi >= 0 && dxi < CW && dyi >= 0 && dyi < CH && p != 0) begin
              exp_q.push_back('{dyi * CW + dxi, p, 1'b1, ra});
              fb_exp[dyi * CW + dxi] = p;
            end
          end
      end
    end
    exp_t = NPIX + area + SLOTS + 3;
  endtask

  task automatic clear_slots();
    for (int s = 0; s < SLOTS; s++) begin
      sx[s] = 0; sy[s] = 0; sw[s] = 0; sh[s] = 0; px[s] = 0; py[s] = 0;
    end
  endtask

  task automatic set_slot(input int s, input int x, input int y, input int w,
                          input int h, input int cx, input int cy);
    sx[s] = x; sy[s] = y; sw[s] = w; sh[s] = h; px[s] = cx; py[s] = cy;
  endtask

  task automatic drive_slots();
    for (int s = 0; s < SLOTS; s++) begin
      bus.sprite[s] = {12'(sx[s]), 12'(sy[s]), 12'(sw[s]), 12'(sh[s])};
      bus.pos[s]    = {12'(px[s]), 12'(py[s])};
    end
  endtask

  // Write monitor: compares each DUT write with the head of the expected list.
  always @(negedge clk) begin
    wr_t e;
    if (rst === 1'b1 && bus.fb_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: addr %0d data %0d, no write expected",
                 bus.fb_addr, bus.fb_data);
      end else begin
        e = exp_q.pop_front();
        checks++;
        if (int'(bus.fb_addr) != e.addr || int'(bus.fb_data) != e.data ||
            (e.has_rom && prev_rom != e.rom)) begin
          errors++;
          $display("FAIL write_seq: addr %0d data %0d rom %0d, expected addr %0d data %0d rom %0d",
                   bus.fb_addr, bus.fb_data, prev_rom, e.addr, e.data, e.rom);
        end
        if (e.has_rom) begin
          if (sprite_writes == 0) begin
            first_rom  = prev_rom;
            first_addr = int'(bus.fb_addr);
          end
          sprite_writes++;
        end
      end
      if (int'(bus.fb_addr) < NPIX) fb_mem[int'(bus.fb_addr)] = int'(bus.fb_data);
    end
    if (rst === 1'b1 && bus.overrun === 1'b1) ovr_cnt++;
    prev_rom = int'(bus.rom_addr);
  end

  task automatic pulse_start();
    @(negedge clk);
    bus.frame_start = 1'b1;
  endtask

  task automatic run_frame(input int exp_ovr, input bit snap_test);
    int sel0, t0, mism;
    bit done;
    build_model();
    drive_slots();
    sprite_writes = 0;
    ovr_cnt       = 0;
    first_rom     = -1;
    first_addr    = -1;
    sel0          = int'(bus.fb_sel);
    pulse_start();
    @(posedge clk);
    #1 t0 = cyc;
    @(negedge clk);
    bus.frame_start = 1'b0;
    chk("finished_drop", bus.painter_finished, 0);
    if (snap_test) begin
      repeat (40) @(negedge clk);
      px[18] += 9;
      py[18] -= 3;
      sw[18] = 5;
      drive_slots();
      bus.frame_start = 1'b1;
      @(negedge clk);
      bus.frame_start = 1'b0;
    end
    done = 1'b0;
    for (int i = 0; i < NPIX + 4000 && !done; i++) begin
      @(negedge clk);
      if (bus.painter_finished === 1'b1) done = 1'b1;
    end
    last_t = cyc - t0;
    chk("finish_timeout", done, 1);
    chk("frame_cycles", last_t, exp_t);
    chk("fb_sel_toggle", bus.fb_sel, sel0 ^ 1);
    chk("writes_missing", exp_q.size(), 0);
    chk("overrun_pulses", ovr_cnt, exp_ovr);
    mism = 0;
    for (int a = 0; a < NPIX; a++) if (fb_mem[a] != fb_exp[a]) mism++;
    chk("fb_image", mism, 0);
    exp_q.delete();
  endtask

  initial begin
    bit reached;
    rst             = 1'b0;
    bus.frame_start = 1'b0;
    bus.sprite      = '0;
    bus.pos         = '0;
    clear_slots();
    #12;
    chk("rst_fb_we", bus.fb_we, 0);
    chk("rst_finished", bus.painter_finished, 0);
    chk("rst_fb_sel", bus.fb_sel, 0);
    chk("rst_overrun", bus.overrun, 0);
    chk("rst_rom_addr", bus.rom_addr, 0);
    chk("rst_fb_addr", bus.fb_addr, 0);
    chk("rst_fb_data", bus.fb_data, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // Empty frame: clear only.
    run_frame(0, 0);
    chk("empty_time_lit", last_t, 1315);
    chk("empty_sprite_writes", sprite_writes, 0);

    // Single 4x2 sprite, sheet (10,5), canvas (10,3), all pixels 3.
    clear_slots();
    set_slot(3, 10, 5, 4, 2, 10, 3);
    run_frame(0, 0);
    chk("single_time_lit", last_t, 1323);
    chk("single_first_rom", first_rom, 12240);
    chk("single_first_addr", first_addr, 202);
    chk("single_writes", sprite_writes, 8);
    chk("single_px_205", fb_mem[205], 3);
    chk("single_px_269", fb_mem[269], 3);
    chk("single_px_206", fb_mem[206], 0);

    // Clipping on the left edge and bottom-right corner.
    clear_slots();
    set_slot(0, 0, 0, 4, 1, -2, 0);
    run_frame(0, 0);
    chk("clip_left_writes", sprite_writes, 2);
    chk("clip_left_px0", fb_mem[0], 3);
    chk("clip_left_px1", fb_mem[1], 3);
    clear_slots();
    set_slot(31, 0, 0, 4, 4, CW - 2, CH - 1);
    run_frame(0, 0);
    chk("clip_corner_writes", sprite_writes, 2);
    chk("clip_corner_px", fb_mem[NPIX - 2], 3);
    chk("clip_corner_last", fb_mem[NPIX - 1], 3);

    // Overlap: slot 5 over slot 0, then transparent slot 5 pixel.
    rom_mode = 0;
    clear_slots();
    set_slot(0, 0, 1, 1, 1, 5, 5);
    set_slot(5, 0, 2, 1, 1, 5, 5);
    run_frame(0, 0);
    chk("overlap_top", fb_mem[325], 2);
    set_slot(5, 0, 4, 1, 1, 5, 5);
    run_frame(0, 0);
    chk("overlap_transparent", fb_mem[325], 1);
    chk("overlap_writes", sprite_writes, 1);

    // Snapshot: slot 18 changed and frame_start re-pulsed mid-clear.
    rom_mode = 2;
    clear_slots();
    set_slot(18, 3, 7, 3, 3, 20, 10);
    run_frame(1, 1);
    chk("snap_old_pos", fb_mem[10 * CW + 20], 3);
    chk("snap_new_pos", fb_mem[7 * CW + 29], 0);

    // Asynchronous reset in the middle of a blit.
    clear_slots();
    set_slot(2, 0, 0, 10, 10, 30, 5);
    build_model();
    drive_slots();
    sprite_writes = 0;
    pulse_start();
    @(negedge clk);
    bus.frame_start = 1'b0;
    reached = 1'b0;
    for (int i = 0; i < NPIX + 500 && !reached; i++) begin
      @(negedge clk);
      if (sprite_writes > 2 && bus.fb_we === 1'b1) reached = 1'b1;
    end
    chk("blit_reached", reached, 1);
    #2 rst = 1'b0;
    #1;
    chk("arst_fb_we", bus.fb_we, 0);
    chk("arst_finished", bus.painter_finished, 0);
    chk("arst_fb_sel", bus.fb_sel, 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    chk("arst_hold_finished", bus.painter_finished, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Randomized scenes.
    rom_mode = 1;
    for (int f = 0; f < 6; f++) begin
      clear_slots();
      for (int s = 0; s < SLOTS; s++) begin
        set_slot(s, int'($urandom_range(2000)), int'($urandom_range(200)),
                 int'($urandom_range(10)), int'($urandom_range(10)),
                 int'($urandom_range(80)) - 12, int'($urandom_range(30)) - 8);
        if ($urandom_range(3) == 0) sw[s] = 0;
      end
      run_frame(0, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sprite_painter.md
Name: sprite_painter

Overview:
- Consumer end of the runner's render-slot interface. On each frame trigger it snapshots all `sprite`/`pos` slots, clears the back framebuffer, then blits each non-empty slot from the sprite-sheet ROM in slot order (0 = bottom layer, highest index on top).
- Raises `painter_finished` when the frame is complete, which steps the game loop.
- Sits between the runner and the framebuffer/VGA scan-out.

Parameters:
- RENDER_SLOTS, 32, number of slots snapshotted and painted.
- CANVAS_W, 1280, framebuffer width in pixels (2x of the 640-wide game).
- CANVAS_H, 300, framebuffer height in pixels.
- SHEET_W, 2446, sprite-sheet ROM row pitch in pixels.
- ROM_AW, 19, sprite ROM address width.
- FB_AW, 19, framebuffer address width.
- PIX_W, 2, bits per pixel; value 0 is transparent and is also the background.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- frame_start  in  1  one-cycle pulse from the scan-out at vblank; requests a new paint.
- sprite  in  RENDER_SLOTS x sprite_t  per-slot sheet x, y, w, h.
- pos  in  RENDER_SLOTS x pos_t  per-slot signed canvas x, y.
- rom_addr  out  ROM_AW  sprite ROM read address.
- rom_data  in  PIX_W  ROM pixel, valid exactly 1 cycle after rom_addr.
- fb_we  out  1  framebuffer write enable.
- fb_addr  out  FB_AW  framebuffer write address = y*CANVAS_W + x.
- fb_data  out  PIX_W  framebuffer write data.
- fb_sel  out  1  back-buffer index being painted; scan-out shows ~fb_sel.
- painter_finished  out  1  high while idle with a completed frame.
- overrun  out  1  one-cycle pulse when frame_start arrives while busy.

Behaviour:
- Reset values (rst low, asynchronous): state IDLE, painter_finished 0, fb_sel 0, fb_we 0, overrun 0, rom_addr 0, fb_addr 0, fb_data 0, snapshot cleared.
- IDLE:
  - frame_start -> copy all sprite/pos into the snapshot in the same edge, drop painter_finished, go to CLEAR.
  - Runner changes after this edge do not affect the frame.
- CLEAR:
  - fb_we=1, fb_data=0, fb_addr counts 0..CANVAS_W*CANVAS_H-1, one pixel per cycle.
  - After the last address, slot index = 0, go to LOAD.
- LOAD:
  - If the slot has w==0 or h==0, skip it (index+1, 1 cycle).
  - Otherwise init col=0, row=0, go to BLIT.
  - When index == RENDER_SLOTS, go to DRAIN.
- BLIT issue stage, one pixel per cycle:
  - rom_addr = (sheet_y+row)*SHEET_W + sheet_x + col.
  - Canvas dx = pos.x+col, dy = pos.y+row, computed signed 13-bit.
  - Pipeline register carries valid, in_bounds (0<=dx<CANVAS_W and 0<=dy<CANVAS_H) and the fb address.
  - col wraps at w-1 to 0 with row+1. After row h-1 / col w-1: index+1, go to LOAD.
- Write stage (1 cycle after issue): fb_we = valid & in_bounds & (rom_data != 0); fb_addr/fb_data come from the pipeline register.
- Clipping and transparency: off-canvas or transparent pixels are never written. Negative pos (e.g. a scrolling horizon at x=-1200) is legal.
- Overlap: later slots overwrite earlier ones (painter's algorithm).
- DRAIN: one cycle to retire the last pipeline entry, then DONE.
- DONE (1 cycle): toggle fb_sel, set painter_finished=1, return to IDLE.
- painter_finished stays 1 until the next accepted frame_start; the runner uses its rising edge.
- frame_start in any state other than IDLE is ignored, and overrun pulses for 1 cycle.
- frame_start in the same cycle as DONE is ignored and raises overrun.
- Reset mid-operation aborts immediately: the in-flight write is dropped, fb_sel returns to 0, no painter_finished edge occurs.
- Width rules:
  - rom_addr and fb_addr use unsigned arithmetic with no wrap; the product is computed at ROM_AW/FB_AW width.
  - sprite_t fields are unsigned 12-bit; pos_t fields are signed 12-bit and are sign-extended before the add.
- Frame time is CANVAS_W*CANVAS_H + sum(w*h over non-empty slots) + (number of slots) + 3 cycles, which must be below CLK_PER_FRAME. The bench checks this with the worst-case game scene.

Test Plan:
- Empty frame: all slots w=h=0, pulse frame_start -> exactly 384000 writes of 0, painter_finished rises 384000+32+3 cycles later, fb_sel 0->1.
- Single 4x2 sprite, sheet (10,5), pos (100,20), ROM pixels all 3 -> 8 writes at fb_addr 25700..25703 and 26980..26983; rom_addr starts at 12240.
- Clipping: 4x1 sprite at pos (-2,0) -> writes only at fb_addr 0 and 1. Sprite at pos (1278,299) size 4x4 -> writes only at 384 000-2 and 384 000-1.
- Transparency/overlap: slot 0 and slot 5 cover the same pixel with values 1 and 2 -> final value 2. A slot-5 pixel of 0 leaves 1.
- Snapshot/overrun: change slot 18 pos mid-CLEAR and pulse frame_start -> painted pos is the old one, overrun pulses once, no restart.
- Async reset asserted mid-BLIT -> fb_we 0 and painter_finished 0 without a clock edge. After release, the next frame_start completes normally.
